clic_core: RTL and testbench
============================

# clic_core

Nested, vectored interrupt-controller core with memory-mapped CSRs and a return-address/priority stack. It sits between the fetch stage and the CSR unit. Each cycle it either passes the fetch PC through, redirects it to the highest-priority eligible vector, or restores a preempted context when the return sentinel is fetched. Per-vector CSRs, the threshold CSR and the stack depth are accessed with standard RISC-V Zicsr operations.

## Interface
- VecSize, 8: number of interrupt vectors (max 32).
- PrioLevels, 8: priority levels; PrioWidth = clog2(PrioLevels); also the stack depth.
- IMemAddrWidth, 20: byte-address width of instruction memory.
- VecCsrBase, 'hb00: vector CSR k is at VecCsrBase+k.
- EntryCsrBase, 'hb20: entry CSR k is at EntryCsrBase+k.
- MIntThreshAddr, 'h347: threshold CSR address.
- StackDepthAddr, 'h350: read-only stack-depth CSR address.

Ports:
- clk  in  1  clock; one clock.
- reset  in  1  synchronous, active-high reset.
- csr_enable  in  1  CSR instruction valid this cycle.
- csr_addr  in  12  CSR address.
- rs1_zimm  in  5  immediate for the I-forms.
- rs1_data  in  32  rs1 operand.
- csr_op  in  3  funct3: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI; other codes perform no write.
- pc_in  in  IMemAddrWidth  fetch PC; all-ones is the return sentinel.
- out  out  32  zero-extended current value of the addressed CSR; 0 if no CSR matches.
- pc_out  out  IMemAddrWidth  next PC.

## Operation
- **Vector CSR k:** IMemAddrWidth-2 bits, holds a word address. The redirect target is {vec, 2'b00}.
- **Entry CSR k:** PrioWidth+2 bits.
  - bit0 pended.
  - bit1 enabled.
  - [PrioWidth+1:2] prio.
  - Pending is never auto-cleared; software clears it.
- **Threshold CSR:** PrioWidth bits.
- **CSR writes:** when csr_enable is set and the address matches, the operand is rs1_data (ops 1–3) or zero-extended rs1_zimm (ops 5–7).
  - RW: new = operand.
  - RS: new = old | operand.
  - RC: new = old & ~operand.
  - The result is truncated to the register width.
- **Stack-depth CSR:** read-only; writes are ignored.
- **Arbitration:**
  - Vector k is eligible iff enabled && pended && prio > threshold.
  - The winner has the strictly highest prio; on ties the lowest index wins.
  - take = a winner exists.
- **Decision, first match wins:**
  1. Tail-chain (see Configuration): pc_in == all-ones && take. pc_out = winner target; no push or pop; threshold unchanged.
  2. Take: pc_out = winner target; push {pc_in, threshold}; threshold <= winner prio.
  3. Return: pc_in == all-ones. Pop; pc_out = stacked addr; threshold <= stacked prio.
  4. Otherwise pc_out = pc_in.
- **Write conflict:** a hardware threshold update overrides a same-cycle CSR write to the threshold.
- **Stack:** LIFO of {addr, prio}, PrioLevels entries; the top entry is visible combinationally.
  - Push when full: ignored.
  - Pop when empty: returns all-zero data; depth stays 0.

## Timing
- out and pc_out are combinational from the current inputs and state, in the same cycle.
- CSR writes, threshold updates, push and pop take effect at the next rising clk edge.
- A CSR write to an entry takes effect for arbitration one cycle later.
- **Reset state:**
  - All CSRs 0.
  - Stack empty.
  - Depth 0.
  - After reset, pc_out = pc_in and out = 0 for every address.
- Reset asserted mid-operation discards all stacked contexts at that edge.

## Configuration
- **CLIC_TAIL_CHAIN_EN defined:** decision case 1 is active.
- **Not defined:** case 1 is removed.
  - The sentinel with a pending eligible interrupt pops first (case 3).
  - The interrupt is then taken in a later cycle when the restored threshold allows it.

## Test plan
- **Reset:** pc_in=0x100 -> pc_out=0x100; reading 'h347, 'hb00, 'hb20 and 'h350 gives out=0.
- **CSR ops:**
  - CSRRW 'hb20 <= 0x1F -> out=0x1F.
  - CSRRCI zimm=1 -> 0x1E.
  - CSRRS rs1=1 -> 0x1F.
  - A write to 'h350 leaves 0.
- **Take:** vec1=0x40, entry1 = prio 3, enabled, pended; pc_in=0x200 -> pc_out=0x100; next cycle threshold=3 and depth=1.
- **Nesting and return:**
  - entry2 prio 5 preempts with pc_in=0x300; depth becomes 2.
  - Clear both pendings. Sentinel -> pc_out=0x300, threshold=3.
  - Sentinel again -> pc_out=0x200, threshold=0.
- **Tie and threshold:**
  - Vectors 0 and 3 both at prio 2 -> vector 0 wins.
  - Threshold set to 2 -> no take.
- **Tail-chain:**
  - With CLIC_TAIL_CHAIN_EN: sentinel with an eligible interrupt -> pc_out = vector target; depth unchanged.
  - Without it: pop first, then take.

Source files
------------

// File: rtl/clic_core.sv
// clic_core: nested, vectored interrupt controller core.
// Arbitrates pended/enabled vectors against a priority threshold, redirects the
// fetch PC to the winning vector and keeps a LIFO of preempted {pc, threshold}
// contexts that is unwound when the all-ones return sentinel is fetched.
// Optional feature macro: CLIC_TAIL_CHAIN_EN (sentinel + eligible interrupt
// jumps straight to the new vector without a pop/push pair).
module clic_core #(
    parameter int unsigned VecSize        = 8,
    parameter int unsigned PrioLevels     = 8,
    parameter int unsigned IMemAddrWidth  = 20,
    parameter logic [11:0] VecCsrBase     = 12'hb00,
    parameter logic [11:0] EntryCsrBase   = 12'hb20,
    parameter logic [11:0] MIntThreshAddr = 12'h347,
    parameter logic [11:0] StackDepthAddr = 12'h350
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_enable,
    input  logic [11:0]              csr_addr,
    input  logic [4:0]               rs1_zimm,
    input  logic [31:0]              rs1_data,
    input  logic [2:0]               csr_op,
    input  logic [IMemAddrWidth-1:0] pc_in,
    output logic [31:0]              out,
    output logic [IMemAddrWidth-1:0] pc_out
);

    localparam int unsigned PrioWidth  = $clog2(PrioLevels);
    localparam int unsigned DepthWidth = $clog2(PrioLevels + 1);
    localparam int unsigned VecWidth   = IMemAddrWidth - 2;
    localparam int unsigned EntryWidth = PrioWidth + 2;
    localparam int unsigned IdxWidth   = (VecSize > 1) ? $clog2(VecSize) : 1;
    localparam int unsigned SlotWidth  = (PrioLevels > 1) ? $clog2(PrioLevels) : 1;

    logic [VecWidth-1:0]      vec_q      [VecSize];
    logic [EntryWidth-1:0]    entry_q    [VecSize];
    logic [PrioWidth-1:0]     thresh_q;
    logic [IMemAddrWidth-1:0] stk_addr_q [PrioLevels];
    logic [PrioWidth-1:0]     stk_prio_q [PrioLevels];
    logic [DepthWidth-1:0]    depth_q;

    logic [VecSize-1:0]       vec_hit, entry_hit;
    logic                     thresh_hit;
    logic                     wr_op;
    logic [31:0]              operand, wr_val;
    logic                     take;
    logic [IdxWidth-1:0]      win_idx;
    logic [PrioWidth-1:0]     win_prio;
    logic [DepthWidth-1:0]    top_slot;
    logic [IMemAddrWidth-1:0] top_addr;
    logic [PrioWidth-1:0]     top_prio;
    logic                     sentinel, do_tail, do_take, do_pop;

    // CSR address decode and zero-extended read-back of the addressed register
    always_comb begin
        out        = '0;
        vec_hit    = '0;
        entry_hit  = '0;
        thresh_hit = (csr_addr == MIntThreshAddr);
        for (int k = 0; k < VecSize; k++) begin
            if (csr_addr == VecCsrBase + 12'(k)) begin
                vec_hit[k] = 1'b1;
                out        = 32'(vec_q[k]);
            end
            if (csr_addr == EntryCsrBase + 12'(k)) begin
                entry_hit[k] = 1'b1;
                out          = 32'(entry_q[k]);
            end
        end
        if (thresh_hit) out = 32'(thresh_q);
        if (csr_addr == StackDepthAddr) out = 32'(depth_q);
    end

    // Zicsr read-modify-write value; funct3[1:0]==0 (codes 0 and 4) never writes
    always_comb begin
        wr_op   = csr_enable && (csr_op[1:0] != 2'b00);
        operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
        case (csr_op[1:0])
            2'b01:   wr_val = operand;
            2'b10:   wr_val = out | operand;
            2'b11:   wr_val = out & ~operand;
            default: wr_val = out;
        endcase
    end

    // Arbitration: strictly-greater compare keeps the lowest index on ties
    always_comb begin
        take     = 1'b0;
        win_idx  = '0;
        win_prio = '0;
        for (int k = 0; k < VecSize; k++) begin
            if (entry_q[k][1] && entry_q[k][0] && (entry_q[k][EntryWidth-1:2] > thresh_q) &&
                (!take || (entry_q[k][EntryWidth-1:2] > win_prio))) begin
                take     = 1'b1;
                win_idx  = IdxWidth'(k);
                win_prio = entry_q[k][EntryWidth-1:2];
            end
        end
    end

    // Stack top view and the per-cycle redirect / return decision
    always_comb begin
        top_slot = depth_q - 1'b1;
        top_addr = '0;
        top_prio = '0;
        if (depth_q != '0) begin
            top_addr = stk_addr_q[top_slot[SlotWidth-1:0]];
            top_prio = stk_prio_q[top_slot[SlotWidth-1:0]];
        end
        sentinel = &pc_in;
`ifdef CLIC_TAIL_CHAIN_EN
        do_tail = sentinel && take;
`else
        do_tail = 1'b0;
`endif
        do_take = take && !sentinel;
        do_pop  = sentinel && !do_tail;
        if (do_tail || do_take) begin
            pc_out = {vec_q[win_idx], 2'b00};
        end else if (do_pop) begin
            pc_out = top_addr;
        end else begin
            pc_out = pc_in;
        end
    end

    // State update: CSR writes, threshold (hardware wins), push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < VecSize; k++) begin
                vec_q[k]   <= '0;
                entry_q[k] <= '0;
            end
            for (int s = 0; s < PrioLevels; s++) begin
                stk_addr_q[s] <= '0;
                stk_prio_q[s] <= '0;
            end
            thresh_q <= '0;
            depth_q  <= '0;
        end else begin
            for (int k = 0; k < VecSize; k++) begin
                if (wr_op && vec_hit[k])   vec_q[k]   <= wr_val[VecWidth-1:0];
                if (wr_op && entry_hit[k]) entry_q[k] <= wr_val[EntryWidth-1:0];
            end
            if (do_take) begin
                thresh_q <= win_prio;
            end else if (do_pop) begin
                thresh_q <= top_prio;
            end else if (wr_op && thresh_hit) begin
                thresh_q <= wr_val[PrioWidth-1:0];
            end
            if (do_take && (depth_q != DepthWidth'(PrioLevels))) begin
                stk_addr_q[depth_q[SlotWidth-1:0]] <= pc_in;
                stk_prio_q[depth_q[SlotWidth-1:0]] <= thresh_q;
                depth_q <= depth_q + 1'b1;
            end else if (do_pop && (depth_q != '0)) begin
                depth_q <= depth_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clic_core.sv
// Bench for clic_core: directed scenarios plus randomized CSR/fetch traffic,
// every cycle checked against a queue-based reference model.
module tb_clic_core;

    localparam logic [19:0] Sent = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic [2:0]  csr_op;
    logic [19:0] pc_in;
    logic [31:0] out;
    logic [19:0] pc_out;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] obs_pc, obs_out;

    clic_core dut (
        .clk        (clk),
        .reset      (reset),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .rs1_zimm   (rs1_zimm),
        .rs1_data   (rs1_data),
        .csr_op     (csr_op),
        .pc_in      (pc_in),
        .out        (out),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int addr;
        int prio;
    } ctx_t;
    int   m_vec  [8];
    int   m_pend [8];
    int   m_en   [8];
    int   m_prio [8];
    int   m_thr;
    ctx_t m_stk  [$];

    function automatic int m_read(input logic [11:0] a);
        int ai = int'(a);
        if (ai >= 'hb00 && ai < 'hb08) return m_vec[ai - 'hb00];
        if (ai >= 'hb20 && ai < 'hb28)
            return m_prio[ai - 'hb20] * 4 + m_en[ai - 'hb20] * 2 + m_pend[ai - 'hb20];
        if (ai == 'h347) return m_thr;
        if (ai == 'h350) return m_stk.size();
        return 0;
    endfunction

    function automatic int m_winner();
        int best = -1;
        for (int k = 0; k < 8; k++)
            if (m_en[k] != 0 && m_pend[k] != 0 && m_prio[k] > m_thr &&
                (best < 0 || m_prio[k] > m_prio[best]))
                best = k;
        return best;
    endfunction

    function automatic int m_pc(input logic [19:0] pc);
        int  w    = m_winner();
        bit  sent = (pc == Sent);
`ifdef CLIC_TAIL_CHAIN_EN
        if (sent && w >= 0) return m_vec[w] * 4;
`endif
        if (w >= 0 && !sent) return m_vec[w] * 4;
        if (sent) return (m_stk.size() > 0) ? m_stk[$].addr : 0;
        return int'(pc);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_vec[k] = 0; m_pend[k] = 0; m_en[k] = 0; m_prio[k] = 0;
        end
        m_thr = 0;
        m_stk.delete();
    endtask

    task automatic m_commit(input bit en, input logic [11:0] a, input logic [4:0] z,
                            input logic [31:0] d, input logic [2:0] op, input logic [19:0] pc);
        int          w       = m_winner();
        int          wp      = (w >= 0) ? m_prio[w] : 0;
        bit          sent    = (pc == Sent);
        int          old_thr = m_thr;
        int          ai      = int'(a);
        bit          tail    = 1'b0;
        logic [31:0] opnd, oldv, nv;
        ctx_t        c;
`ifdef CLIC_TAIL_CHAIN_EN
        tail = sent && (w >= 0);
`endif
        if (en && op[1:0] != 2'b00) begin
            opnd = op[2] ? {27'd0, z} : d;
            oldv = m_read(a);
            case (op[1:0])
                2'b01:   nv = opnd;
                2'b10:   nv = oldv | opnd;
                default: nv = oldv & ~opnd;
            endcase
            if (ai >= 'hb00 && ai < 'hb08) m_vec[ai - 'hb00] = int'(nv & 32'h3FFFF);
            if (ai >= 'hb20 && ai < 'hb28) begin
                m_pend[ai - 'hb20] = int'(nv[0]);
                m_en[ai - 'hb20]   = int'(nv[1]);
                m_prio[ai - 'hb20] = int'((nv >> 2) & 32'h7);
            end
            if (ai == 'h347) m_thr = int'(nv & 32'h7);
        end
        if (!tail && w >= 0 && !sent) begin
            if (m_stk.size() < 8) m_stk.push_back('{int'(pc), old_thr});
            m_thr = wp;
        end else if (!tail && sent) begin
            if (m_stk.size() > 0) begin
                c     = m_stk.pop_back();
                m_thr = c.prio;
            end else begin
                m_thr = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, clock, update model
    task automatic apply(input bit en, input logic [11:0] a, input logic [4:0] z,
                         input logic [31:0] d, input logic [2:0] op, input logic [19:0] pc);
        csr_enable = en; csr_addr = a; rs1_zimm = z; rs1_data = d; csr_op = op; pc_in = pc;
        #1;
        chk("pc_out", {12'd0, pc_out}, 32'(m_pc(pc)));
        chk("out", out, 32'(m_read(a)));
        obs_pc  = {12'd0, pc_out};
        obs_out = out;
        @(posedge clk);
        m_commit(en, a, z, d, op, pc);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [19:0] pc);
        apply(1'b0, a, 5'd0, 32'd0, 3'd0, pc);
    endtask

    task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d,
                      input logic [19:0] pc);
        apply(1'b1, a, d[4:0], d, op, pc);
    endtask

    task automatic do_reset();
        reset = 1'b1; csr_enable = 1'b0; csr_addr = '0; rs1_zimm = '0; rs1_data = '0;
        csr_op = '0; pc_in = 20'h100;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        // Reset state
        do_reset();
        rd(12'h347, 20'h100); chk("rst_pc", obs_pc, 32'h100); chk("rst_thr", obs_out, 32'h0);
        rd(12'hb00, 20'h100); chk("rst_vec0", obs_out, 32'h0);
        rd(12'hb20, 20'h100); chk("rst_entry0", obs_out, 32'h0);
        rd(12'h350, 20'h100); chk("rst_depth", obs_out, 32'h0);

        // Zicsr operations on entry 0
        wr(12'hb20, 3'd1, 32'h1F, 20'h100);
        rd(12'hb20, 20'h100); chk("csrrw", obs_out, 32'h1F);
        wr(12'hb20, 3'd7, 32'h1, 20'h100);
        rd(12'hb20, 20'h100); chk("csrrci", obs_out, 32'h1E);
        wr(12'hb20, 3'd2, 32'h1, 20'h100);
        rd(12'hb20, 20'h100); chk("csrrs", obs_out, 32'h1F);
        do_reset();
        wr(12'h350, 3'd1, 32'h5, 20'h100);
        rd(12'h350, 20'h100); chk("depth_ro", obs_out, 32'h0);

        // Take, nesting and return
        do_reset();
        wr(12'hb01, 3'd1, 32'h40, 20'h200);
        wr(12'hb21, 3'd1, 32'h0F, 20'h200);
        rd(12'h347, 20'h200); chk("take_pc", obs_pc, 32'h100);
        rd(12'h347, 20'h104); chk("take_thr", obs_out, 32'h3);
        rd(12'h350, 20'h108); chk("take_depth", obs_out, 32'h1);
        wr(12'hb02, 3'd1, 32'h80, 20'h108);
        wr(12'hb22, 3'd1, 32'h17, 20'h10c);
        rd(12'h350, 20'h300); chk("nest_pc", obs_pc, 32'h200);
        rd(12'h350, 20'h204); chk("nest_depth", obs_out, 32'h2);
        wr(12'hb21, 3'd3, 32'h1, 20'h208);
        wr(12'hb22, 3'd3, 32'h1, 20'h20c);
        rd(12'h347, Sent);    chk("ret1_pc", obs_pc, 32'h300);
        rd(12'h347, 20'h304); chk("ret1_thr", obs_out, 32'h3);
        rd(12'h347, Sent);    chk("ret2_pc", obs_pc, 32'h200);
        rd(12'h347, 20'h204); chk("ret2_thr", obs_out, 32'h0);
        rd(12'h350, 20'h208); chk("ret_depth", obs_out, 32'h0);

        // Tie at equal priority, then threshold masking
        do_reset();
        wr(12'hb00, 3'd1, 32'h10, 20'h500);
        wr(12'hb03, 3'd1, 32'h30, 20'h500);
        wr(12'hb20, 3'd1, 32'h0B, Sent);
        wr(12'hb23, 3'd1, 32'h0B, Sent);
        rd(12'h350, 20'h500); chk("tie_pc", obs_pc, 32'h40);
        do_reset();
        wr(12'hb00, 3'd1, 32'h10, 20'h500);
        wr(12'hb03, 3'd1, 32'h30, 20'h500);
        wr(12'hb20, 3'd1, 32'h09, 20'h500);
        wr(12'hb23, 3'd1, 32'h09, 20'h500);
        wr(12'h347, 3'd5, 32'h2, 20'h500);
        wr(12'hb20, 3'd2, 32'h2, 20'h500);
        wr(12'hb23, 3'd2, 32'h2, 20'h500);
        rd(12'h347, 20'h500); chk("thr_pc", obs_pc, 32'h500); chk("thr_val", obs_out, 32'h2);

        // Sentinel with an eligible interrupt
        do_reset();
        wr(12'hb01, 3'd1, 32'h40, 20'h200);
        wr(12'hb21, 3'd1, 32'h0F, 20'h200);
        rd(12'h347, 20'h200); chk("tc_take_pc", obs_pc, 32'h100);
        wr(12'hb02, 3'd1, 32'hC0, 20'h104);
        wr(12'hb22, 3'd1, 32'h15, 20'h108);
        wr(12'hb22, 3'd2, 32'h2, 20'h10c);
        rd(12'h350, Sent);
`ifdef CLIC_TAIL_CHAIN_EN
        chk("tc_pc", obs_pc, 32'h300);
        rd(12'h350, 20'h110); chk("tc_depth", obs_out, 32'h1);
`else
        chk("pop_first_pc", obs_pc, 32'h200);
        rd(12'h350, 20'h204); chk("late_take_pc", obs_pc, 32'h300); chk("pop_depth", obs_out, 32'h0);
        rd(12'h350, 20'h304); chk("late_take_depth", obs_out, 32'h1);
`endif

        // Reset mid-operation discards stacked contexts
        do_reset();
        rd(12'h350, 20'h100); chk("mid_rst_depth", obs_out, 32'h0);
        rd(12'h347, Sent);    chk("empty_pop_pc", obs_pc, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            logic [19:0] pc;
            case ($urandom_range(0, 5))
                0:       a = 12'hb00 + 12'($urandom_range(0, 7));
                1:       a = 12'hb20 + 12'($urandom_range(0, 7));
                2:       a = 12'h347;
                3:       a = 12'h350;
                4:       a = 12'($urandom);
                default: a = 12'hb08 + 12'($urandom_range(0, 3));
            endcase
            pc = ($urandom_range(0, 3) == 0) ? Sent : 20'($urandom);
            apply(1'($urandom_range(0, 1)), a, 5'($urandom), $urandom, 3'($urandom), pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
